// File: rtl/interrupt_ack_sequencer_pkg.sv
// rtl/interrupt_ack_sequencer_pkg.sv - shared state encoding, constants and priority encoder
package interrupt_ack_sequencer_pkg;

    // Acknowledge sequence states: two INTA pulses with a gap between them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK1  = 2'd1;
    localparam logic [1:0] ST_WAIT2 = 2'd2;
    localparam logic [1:0] ST_ACK2  = 2'd3;

    // Level reported when the request vanished before the first INTA edge
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Result of a priority encode: index of the lowest set bit plus a valid flag
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Lowest set bit wins (bit 0 is the highest priority level)
    function automatic prio_t prio_encode(input logic [7:0] req);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = i[2:0];
            end
        end
        return r;
    endfunction

    // One-hot decode of a 3-bit level
    function automatic logic [7:0] level_onehot(input logic [2:0] lvl);
        return 8'b0000_0001 << lvl;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_inta_synchroniser.sv
// rtl/interrupt_ack_sequencer_inta_synchroniser.sv - INTA pin synchroniser with edge pulses
module inta_synchroniser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inta_n_i,
    output logic inta_fall_o,
    output logic inta_rise_o
);

    // Flops preset to 1 so the inactive (high) pin produces no edge out of reset.
    // SYNC_STAGES must be at least 2 for the shift below to be meaningful.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Shift the raw pin through the synchroniser chain, then keep one delayed copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Single-cycle pulses; the consuming FSM updates on the edge that retires them
    assign inta_fall_o = edge_q & ~sync_q[SYNC_STAGES-1];
    assign inta_rise_o = ~edge_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - priority resolve, INT, INTA sequence, ISR and vector drive
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INTA,
    input  logic [7:0] irr_masked,
    input  logic [7:0] icw2,
    input  logic       aeoi,
    input  logic       eoi_pulse,
    input  logic       send_vector_address,
    output logic       INT,
    output logic [7:0] isr,
    output logic [7:0] isr_highest_bit,
    output logic [7:0] clear_irr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    logic       inta_fall;
    logic       inta_rise;

    logic [1:0] state_q, state_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic       int_q, int_d;

    prio_t      win;
    prio_t      isr_low;
    logic       winner_valid;

    // Vector base low bits are replaced by the level and never read
    logic       icw2_low_unused;
    assign icw2_low_unused = ^icw2[2:0];

    inta_synchroniser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .inta_n_i    (INTA),
        .inta_fall_o (inta_fall),
        .inta_rise_o (inta_rise)
    );

    // Fully nested priority: a request only wins if it outranks everything in service
    always_comb begin
        win          = prio_encode(irr_masked);
        isr_low      = prio_encode(isr_q);
        winner_valid = win.valid && (!isr_low.valid || (win.idx < isr_low.idx));
    end

    // Next-state logic for the acknowledge FSM, ISR and INT
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        spurious_d  = spurious_q;
        isr_d       = isr_q;
        clear_irr_d = 8'h00;

        // Non-specific EOI works on the ISR as it was before any set this cycle
        if (eoi_pulse) begin
            isr_d = isr_q & ~isr_highest_bit;
        end

        case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_d = ST_ACK1;
                    if (winner_valid) begin
                        level_d     = win.idx;
                        spurious_d  = 1'b0;
                        isr_d       = isr_d | level_onehot(win.idx);
                        clear_irr_d = level_onehot(win.idx);
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_d = ST_IDLE;
                    if (aeoi && !spurious_q) begin
                        isr_d = isr_d & ~level_onehot(level_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // INT only requested from IDLE, and dropped on the edge that starts the sequence
        int_d = (state_q == ST_IDLE) && !inta_fall && winner_valid;
    end

    // State registers; reset returns the block to idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            level_q     <= 3'd0;
            spurious_q  <= 1'b0;
            isr_q       <= 8'h00;
            clear_irr_q <= 8'h00;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            isr_q       <= isr_d;
            clear_irr_q <= clear_irr_d;
            int_q       <= int_d;
        end
    end

    // Outputs: vector only presented in ACK2, enable withdrawn as the pulse ends
    always_comb begin
        INT             = int_q;
        isr             = isr_q;
        clear_irr       = clear_irr_q;
        isr_highest_bit = isr_low.valid ? level_onehot(isr_low.idx) : 8'h00;
        data_out        = (state_q == ST_ACK2) ? {icw2[7:3], level_q} : 8'h00;
        data_oe         = (state_q == ST_ACK2) && send_vector_address && !inta_rise;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
Upstream stage of the cascade block in the 8259-style programmable interrupt controller. Resolves priority among pending, unmasked requests and raises INT. Runs the two-pulse INTA acknowledge sequence, owns the In-Service Register (ISR), and drives the one-hot highest in-service level consumed by the cascade block. Consumes the cascade block's send_vector_address to decide whether this device places the vector byte on the data bus during the second INTA pulse.

Parameters:
SYNC_STAGES, 2, number of flops synchronising the asynchronous INTA pin into clk (minimum 2).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
INTA  input  1  CPU interrupt-acknowledge strobe, active-low, asynchronous to clk
irr_masked  input  8  pending requests already ANDed with ~IMR; bit 0 = IR0 = highest priority
icw2  input  8  vector base; only bits [7:3] used
aeoi  input  1  automatic-EOI mode (ICW4 bit)
eoi_pulse  input  1  one-cycle non-specific EOI command from the OCW2 decoder
send_vector_address  input  1  from the cascade block; 1 = this device drives the vector
INT  output  1  interrupt request to the CPU, active-high
isr  output  8  In-Service Register
isr_highest_bit  output  8  one-hot highest-priority set ISR bit; 8'h00 if ISR empty
clear_irr  output  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
data_out  output  8  vector byte
data_oe  output  1  data-bus output enable for data_out

Behaviour:
- Reset: state IDLE; isr, isr_highest_bit, clear_irr, data_out = 8'h00; INT, data_oe = 0; synchroniser flops = 1 (INTA inactive).
- INTA is synchronised through SYNC_STAGES flops plus one edge-detect flop. A falling or rising edge registers 1 + SYNC_STAGES clk edges after the pin changes. Default setting: the state update is on the 3rd rising clk after the pin edge.
- Priority resolution is fixed, fully nested, and IR0 highest. Winner = lowest set bit of irr_masked. Winner is valid only if its index is strictly lower than the index of the lowest set isr bit, or isr == 0.
- INT: registered. Asserts 1 cycle after a valid winner exists while state is IDLE. Deasserts in the cycle the first INTA edge is accepted. Stays 0 until state returns to IDLE.
- FSM states:
  - IDLE: on INTA falling edge -> ACK1.
  - ACK1 entry cycle: winner latched as level[2:0]; isr[level] set; clear_irr = one-hot(level) for exactly 1 cycle.
  - ACK1, no valid winner at the edge (spurious): level = 7, isr unchanged, clear_irr = 0.
  - ACK1: on INTA rising edge -> WAIT2.
  - WAIT2: on INTA falling edge -> ACK2.
  - ACK2: data_out = {icw2[7:3], level}. data_oe = send_vector_address, evaluated combinationally each cycle while in ACK2.
  - ACK2: on INTA rising edge: data_oe = 0 in that cycle. If aeoi and not spurious, clear isr[level]. Go to IDLE.
- isr_highest_bit: combinational one-hot of the lowest set isr bit.
- Non-specific EOI: eoi_pulse clears the lowest set isr bit; no effect if isr == 0.
- EOI in the same cycle as the ACK1 set: the clear is computed on the pre-set isr, then the new bit is set.
- A new INTA falling edge is ignored in ACK1 and ACK2. A rising edge is ignored in IDLE and WAIT2.
- Requests arriving after ACK1 do not change level.
- Reset asserted mid-sequence returns to the reset state immediately, without waiting for a clock edge. No partial vector is driven afterwards.

Decomposition:
- Shared package: FSM state encoding (IDLE, ACK1, WAIT2, ACK2), the constant SPURIOUS_LEVEL = 3'd7, and a priority-encode function (lowest set bit -> index plus valid flag). The function is also reused by the cascade block's test bench.
- One sub-module: inta_synchroniser. It takes SYNC_STAGES flops plus the edge detect and outputs inta_fall and inta_rise pulses.

Test Plan:
- Single request: irr_masked = 8'h04, icw2 = 8'h40, send_vector_address = 1, two INTA pulses.
  - INT = 1, then 0 after the first edge.
  - clear_irr = 8'h04 for one cycle; isr = 8'h04; isr_highest_bit = 8'h04.
  - data_out = 8'h42 with data_oe = 1 only during the second pulse.
- Nesting: isr = 8'h10 in service, irr_masked = 8'h20.
  - INT stays 0.
  - Raise irr bit 1: INT = 1; after the acknowledge, isr = 8'h12 and isr_highest_bit = 8'h02.
- AEOI: aeoi = 1, request IR6, icw2 = 8'h08.
  - Vector = 8'h0E.
  - isr[6] clears on the second INTA rising edge; isr = 8'h00 afterwards.
- Spurious: request IR3 withdrawn before the first INTA edge.
  - isr unchanged, clear_irr = 0, vector = {icw2[7:3], 3'd7}.
- Cascade master with slave on IR2: send_vector_address = 0 in ACK2.
  - data_oe stays 0 for the whole pulse; isr[2] still set.
- Reset mid-sequence: assert reset in WAIT2.
  - All outputs are 0 without a clock edge.
  - A following INTA pulse alone produces no data_oe.
